// File: rtl/elm_hidden_sequencer.sv
// Hidden-layer sequencer for the ELM core: drives the perceptron index
// counter, the input MAC and the handshake into the activation stage.
module elm_hidden_sequencer #(
    parameter int N_IN     = 256,
    parameter int IDX_W    = 13,
    parameter int MAX_NEUR = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IDX_W-1:0]        P_index,
    input  logic                    stop,
    output logic                    rst_P,
    output logic                    en_P,
    output logic                    done_256,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [$clog2(N_IN)-1:0] in_addr,
    output logic                    hid_valid,
    input  logic                    hid_ready,
    output logic [IDX_W-1:0]        hid_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int AW = $clog2(N_IN);
    localparam int CW = $clog2(MAX_NEUR + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_STEP, S_ACC, S_LAST, S_OUT, S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_ncnt;
    logic [AW-1:0]     r_in_addr;
    logic [IDX_W-1:0]  r_hid_addr;
    logic              r_err;
    logic              w_acc_end;
    logic              w_hs;
    logic              w_wdog;

    assign w_acc_end = (r_in_addr == AW'(N_IN - 1));
    assign w_hs      = (r_state == S_OUT) && hid_ready;
    assign w_wdog    = w_hs && !stop && (r_ncnt == CW'(MAX_NEUR));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_INIT;
            S_INIT: w_next = S_STEP;
            S_STEP: w_next = S_ACC;
            S_ACC:  if (w_acc_end) w_next = S_LAST;
            S_LAST: w_next = S_OUT;
            S_OUT: begin
                if (w_hs) begin
                    if (stop || w_wdog) w_next = S_FIN;
                    else                w_next = S_STEP;
                end
            end
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ncnt     <= '0;
            r_in_addr  <= '0;
            r_hid_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_ncnt <= '0;
                    end
                end
                S_STEP: begin
                    r_ncnt    <= r_ncnt + CW'(1);
                    r_in_addr <= '0;
                end
                S_ACC:  r_in_addr  <= r_in_addr + AW'(1);
                S_LAST: r_hid_addr <= P_index;
                S_OUT:  if (w_wdog) r_err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Every strobe is a pure state decode, so nothing combinational
    // reaches them from hid_ready or start.
    assign rst_P     = (r_state == S_INIT);
    assign en_P      = (r_state == S_STEP);
    assign mac_clr   = (r_state == S_STEP);
    assign mac_en    = (r_state == S_ACC);
    assign done_256  = (r_state == S_LAST);
    assign hid_valid = (r_state == S_OUT);
    assign done      = (r_state == S_FIN);
    assign busy      = (r_state != S_IDLE);
    assign in_addr   = r_in_addr;
    assign hid_addr  = r_hid_addr;
    assign err       = r_err;

endmodule

// File: tb/tb_elm_hidden_sequencer.sv
// Directed bench for elm_hidden_sequencer with an attached index-counter
// model (load 8182, step +10 mod 2^13, stop registered at index 5100).
module tb_elm_hidden_sequencer;

    localparam int N   = 4;
    localparam int IW  = 13;
    localparam int AW  = 2;
    localparam int NEU = 511;
    // cycles after the accept edge until the done cycle
    localparam int RUN = 2 + NEU * (N + 3);

    logic clk = 1'b0;
    logic rst, start, hid_ready;
    logic [IW-1:0] cnt_p;
    logic cnt_stop;
    logic rst_P, en_P, done_256, mac_clr, mac_en, hid_valid, busy, done, err;
    logic [AW-1:0] in_addr;
    logic [IW-1:0] hid_addr;

    logic wd_start;
    logic [IW-1:0] wd_pidx;
    logic wd_stop;
    logic wd_rst_P, wd_en_P, wd_d256, wd_clr, wd_men, wd_valid;
    logic wd_busy, wd_done, wd_err;
    logic [AW-1:0] wd_in_addr;
    logic [IW-1:0] wd_hid_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    elm_hidden_sequencer #(.N_IN(N), .IDX_W(IW), .MAX_NEUR(512)) dut (
        .clk(clk), .rst(rst), .start(start), .P_index(cnt_p), .stop(cnt_stop),
        .rst_P(rst_P), .en_P(en_P), .done_256(done_256), .mac_clr(mac_clr),
        .mac_en(mac_en), .in_addr(in_addr), .hid_valid(hid_valid),
        .hid_ready(hid_ready), .hid_addr(hid_addr), .busy(busy), .done(done),
        .err(err)
    );

    assign wd_pidx = '0;
    assign wd_stop = 1'b0;

    elm_hidden_sequencer #(.N_IN(N), .IDX_W(IW), .MAX_NEUR(4)) dut_wd (
        .clk(clk), .rst(rst), .start(wd_start), .P_index(wd_pidx),
        .stop(wd_stop), .rst_P(wd_rst_P), .en_P(wd_en_P), .done_256(wd_d256),
        .mac_clr(wd_clr), .mac_en(wd_men), .in_addr(wd_in_addr),
        .hid_valid(wd_valid), .hid_ready(1'b1), .hid_addr(wd_hid_addr),
        .busy(wd_busy), .done(wd_done), .err(wd_err)
    );

    // external perceptron index counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p    <= '0;
            cnt_stop <= 1'b0;
        end else begin
            if (rst_P) begin
                cnt_p    <= 13'd8182;
                cnt_stop <= 1'b0;
            end else if (en_P) begin
                cnt_p <= cnt_p + 13'd10;
            end
            if (done_256) cnt_stop <= (cnt_p == 13'd5100);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int strobes;
        rst = 1'b1; start = 1'b0; wd_start = 1'b0; hid_ready = 1'b1;
        repeat (3) tick;
        checks++;
        if ({rst_P, en_P, done_256, mac_clr, mac_en, hid_valid, busy, done, err}
            !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=0",
                {rst_P, en_P, done_256, mac_clr, mac_en, hid_valid, busy, done, err});
        end
        checks++;
        if (in_addr !== '0 || hid_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr in_addr=%0d hid_addr=%0d want 0", in_addr, hid_addr);
        end
        checks++;
        if (wd_busy !== 1'b0 || wd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_wd busy=%b err=%b want 0", wd_busy, wd_err);
        end
        rst = 1'b0;
        strobes = 0;
        repeat (10) begin
            tick;
            if (rst_P | en_P | done_256 | mac_clr | mac_en | done | busy) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL idle_quiet strobes=%0d want 0", strobes);
        end
    endtask

    task automatic test_full_run;
        int n, k, en, d256, macs, macbad, addrbad, hsbad, ovl, done_at;
        int first_mac, first_last, clrs;
        start = 1'b1; tick; start = 1'b0;
        checks++;
        if (rst_P !== 1'b1) begin
            errors++;
            $display("FAIL init_strobe rst_P=%b want 1", rst_P);
        end
        n = 1; k = 0; en = 0; d256 = 0; macs = 0; macbad = 0; addrbad = 0;
        hsbad = 0; ovl = 0; done_at = 0; first_mac = 0; first_last = 0; clrs = 0;
        while (done_at == 0 && n < 6000) begin
            if ($countones({rst_P, en_P, done_256, done}) > 1) ovl++;
            if (en_P) en++;
            if (done_256) begin
                d256++;
                if (first_last == 0) first_last = n;
            end
            if (mac_clr) begin
                if (clrs > 0 && macs != N) macbad++;
                clrs++;
                macs = 0;
            end
            if (mac_en) begin
                if (first_mac == 0) first_mac = n;
                if (in_addr !== AW'(macs)) addrbad++;
                macs++;
            end
            if (hid_valid && hid_ready) begin
                if (hid_addr !== IW'(10 * k)) hsbad++;
                k++;
            end
            if (done) done_at = n;
            tick;
            n++;
        end
        checks++;
        if (done_at != RUN) begin
            errors++;
            $display("FAIL full_done_cycle got=%0d want=%0d", done_at, RUN);
        end
        checks++;
        if (k != NEU || hsbad != 0) begin
            errors++;
            $display("FAIL full_handshakes got=%0d bad_addr=%0d want=%0d/0", k, hsbad, NEU);
        end
        checks++;
        if (en != NEU || d256 != NEU) begin
            errors++;
            $display("FAIL full_pulses en_P=%0d done_256=%0d want=%0d", en, d256, NEU);
        end
        checks++;
        if (macbad != 0 || macs != N || addrbad != 0) begin
            errors++;
            $display("FAIL full_mac bad=%0d last=%0d addr_bad=%0d want 0/%0d/0",
                macbad, macs, addrbad, N);
        end
        checks++;
        if (first_mac != 3 || first_last != 3 + N) begin
            errors++;
            $display("FAIL full_latency mac=%0d last=%0d want 3/%0d", first_mac, first_last, 3 + N);
        end
        checks++;
        if (ovl != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL full_overlap_err ovl=%0d err=%b want 0/0", ovl, err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_pressure;
        int n, stall_bad, after, done_at;
        bit stalled;
        start = 1'b1; tick; start = 1'b0;
        n = 1; stall_bad = 0; after = -1; done_at = 0; stalled = 0;
        while (done_at == 0 && n < 6000) begin
            if (!stalled && hid_valid && hid_addr == IW'(20)) begin
                stalled = 1;
                hid_ready = 1'b0;
                repeat (5) begin
                    if (!hid_valid || hid_addr !== IW'(20) || en_P || done_256 || mac_clr)
                        stall_bad++;
                    tick;
                    n++;
                end
                hid_ready = 1'b1;
                tick;
                n++;
                while (!hid_valid && n < 6000) begin
                    tick;
                    n++;
                end
                after = int'(hid_addr);
            end
            if (done) done_at = n;
            tick;
            n++;
        end
        checks++;
        if (!stalled || stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall seen=%0d bad=%0d want 1/0", stalled, stall_bad);
        end
        checks++;
        if (after != 30) begin
            errors++;
            $display("FAIL bp_next got=%0d want=30", after);
        end
        checks++;
        if (done_at != RUN + 5) begin
            errors++;
            $display("FAIL bp_done_cycle got=%0d want=%0d", done_at, RUN + 5);
        end
    endtask

    task automatic test_reset_mid_run;
        int n, dones;
        start = 1'b1; tick; start = 1'b0;
        n = 0;
        while (!(mac_en && cnt_p == IW'(100)) && n < 2000) begin
            tick;
            n++;
        end
        checks++;
        if (!(mac_en && cnt_p == IW'(100))) begin
            errors++;
            $display("FAIL mid_reach timeout n=%0d", n);
        end
        rst = 1'b1; tick;
        checks++;
        if ({rst_P, en_P, done_256, mac_clr, mac_en, hid_valid, busy, done, err}
            !== 9'b0 || in_addr !== '0 || hid_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset ctl=%b hid_addr=%0d want 0",
                {rst_P, en_P, done_256, mac_clr, mac_en, hid_valid, busy, done, err}, hid_addr);
        end
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            tick;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_quiet got=%0d want 0", dones);
        end
        start = 1'b1; tick; start = 1'b0;
        checks++;
        if (rst_P !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart rst_P=%b want 1", rst_P);
        end
        n = 0;
        while (!hid_valid && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (!hid_valid || hid_addr !== '0) begin
            errors++;
            $display("FAIL mid_first valid=%b addr=%0d want 1/0", hid_valid, hid_addr);
        end
        rst = 1'b1; tick; rst = 1'b0; tick;
    endtask

    task automatic test_start_ignored;
        int n, k, extra, done_at;
        bit pulsed;
        start = 1'b1; tick; start = 1'b0;
        n = 1; k = 0; extra = 0; done_at = 0; pulsed = 0;
        while (done_at == 0 && n < 6000) begin
            start = 1'b0;
            if (n > 1 && rst_P) extra++;
            if (hid_valid && hid_ready) k++;
            if (mac_en && !pulsed && cnt_p == IW'(50)) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (done) begin
                done_at = n;
                start = 1'b1;
            end
            tick;
            n++;
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || rst_P !== 1'b0) begin
            errors++;
            $display("FAIL ign_fin busy=%b rst_P=%b want 0/0", busy, rst_P);
        end
        tick;
        if (rst_P) extra++;
        checks++;
        if (extra != 0 || !pulsed) begin
            errors++;
            $display("FAIL ign_init extra=%0d pulsed=%0d want 0/1", extra, pulsed);
        end
        checks++;
        if (k != NEU || done_at != RUN) begin
            errors++;
            $display("FAIL ign_run hs=%0d done=%0d want %0d/%0d", k, done_at, NEU, RUN);
        end
    endtask

    task automatic test_watchdog;
        int n, hs;
        bit seen;
        wd_start = 1'b1; tick; wd_start = 1'b0;
        n = 0; hs = 0; seen = 0;
        while (!seen && n < 200) begin
            if (wd_valid) hs++;
            if (wd_done) begin
                seen = 1;
                checks++;
                if (wd_err !== 1'b1) begin
                    errors++;
                    $display("FAIL wd_err_at_done got=%b want 1", wd_err);
                end
            end
            tick;
            n++;
        end
        checks++;
        if (!seen || hs != 4) begin
            errors++;
            $display("FAIL wd_handshakes seen=%0d hs=%0d want 1/4", seen, hs);
        end
        tick;
        checks++;
        if (wd_err !== 1'b1 || wd_busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_sticky err=%b busy=%b want 1/0", wd_err, wd_busy);
        end
        wd_start = 1'b1; tick; wd_start = 1'b0;
        checks++;
        if (wd_err !== 1'b0 || wd_rst_P !== 1'b1) begin
            errors++;
            $display("FAIL wd_clear err=%b rst_P=%b want 0/1", wd_err, wd_rst_P);
        end
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_back_pressure;
        test_reset_mid_run;
        test_start_ignored;
        test_watchdog;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
